// File: rtl/tcdm_shim_arbiter_pkg.sv
// tcdm_shim_arbiter_pkg: shared sizing helper for the TCDM shim arbiter and its meta-ID pool.
// Provides idx_width(n): bits needed to index n entries (at least 1).
package tcdm_shim_arbiter_pkg;
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction
endpackage

// File: rtl/tcdm_meta_id_pool.sv
// tcdm_meta_id_pool: free-list of meta IDs with a per-ID lookup table.
// Ports: clk_i/rst_ni clock and async active-low reset; alloc_i/alloc_id_i/alloc_entry_i claim an ID
// and store its entry; free_i/free_id_i release an ID; rd_id_i/rd_entry_o/rd_busy_o look up an ID;
// lowest_id_o/avail_o give the lowest free ID; outstanding_o counts busy IDs.
module tcdm_meta_id_pool
    import tcdm_shim_arbiter_pkg::*;
#(
    parameter int unsigned NumIds = 8,
    parameter int unsigned EntryWidth = 4,
    localparam int unsigned IdWidth = idx_width(NumIds),
    localparam int unsigned CntWidth = idx_width(NumIds + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_i,
    input  logic [IdWidth-1:0]    alloc_id_i,
    input  logic [EntryWidth-1:0] alloc_entry_i,
    input  logic                  free_i,
    input  logic [IdWidth-1:0]    free_id_i,
    input  logic [IdWidth-1:0]    rd_id_i,
    output logic [EntryWidth-1:0] rd_entry_o,
    output logic                  rd_busy_o,
    output logic [IdWidth-1:0]    lowest_id_o,
    output logic                  avail_o,
    output logic [CntWidth-1:0]   outstanding_o
);
    logic [NumIds-1:0] free_q;
    logic [NumIds-1:0][EntryWidth-1:0] tbl_q;

    // Allocation only targets free IDs and frees only busy ones, so both can apply in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= '1;
            tbl_q  <= '0;
        end else begin
            if (alloc_i) begin
                free_q[alloc_id_i] <= 1'b0;
                tbl_q[alloc_id_i]  <= alloc_entry_i;
            end
            if (free_i) free_q[free_id_i] <= 1'b1;
        end
    end

    always_comb begin
        lowest_id_o   = '0;
        outstanding_o = '0;
        for (int i = int'(NumIds) - 1; i >= 0; i--) begin
            if (free_q[i]) lowest_id_o = IdWidth'(i);
            outstanding_o += CntWidth'(!free_q[i]);
        end
    end

    assign avail_o    = |free_q;
    assign rd_entry_o = tbl_q[rd_id_i];
    assign rd_busy_o  = !free_q[rd_id_i];
endmodule

// File: rtl/tcdm_shim_arbiter.sv
// tcdm_shim_arbiter: round-robin share of one tcdm_shim data port among NumReq requesters,
// remapping requester IDs onto pooled meta IDs and routing out-of-order responses back.
// Ports: clk_i/rst_ni; req_q*/req_p* requester-side request and response channels (one lane per
// requester); data_q*/data_p* shim-side channels; outstanding_o number of busy meta IDs.
module tcdm_shim_arbiter
    import tcdm_shim_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxOutStandingTrans = 8,
    parameter int unsigned ReqIdWidth = 3,
    localparam int unsigned StrbWidth = DataWidth / 8,
    localparam int unsigned MetaIdWidth = idx_width(MaxOutStandingTrans),
    localparam int unsigned CntWidth = idx_width(MaxOutStandingTrans + 1),
    localparam int unsigned ReqIdxWidth = idx_width(NumReq)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0][AddrWidth-1:0]     req_qaddr_i,
    input  logic [NumReq-1:0]                    req_qwrite_i,
    input  logic [NumReq-1:0][3:0]               req_qamo_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     req_qdata_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]     req_qstrb_i,
    input  logic [NumReq-1:0][ReqIdWidth-1:0]    req_qid_i,
    input  logic [NumReq-1:0]                    req_qvalid_i,
    output logic [NumReq-1:0]                    req_qready_o,
    output logic [NumReq-1:0][DataWidth-1:0]     req_pdata_o,
    output logic [NumReq-1:0]                    req_perror_o,
    output logic [NumReq-1:0][ReqIdWidth-1:0]    req_pid_o,
    output logic [NumReq-1:0]                    req_pvalid_o,
    input  logic [NumReq-1:0]                    req_pready_i,
    output logic [AddrWidth-1:0]                 data_qaddr_o,
    output logic                                 data_qwrite_o,
    output logic [3:0]                           data_qamo_o,
    output logic [DataWidth-1:0]                 data_qdata_o,
    output logic [StrbWidth-1:0]                 data_qstrb_o,
    output logic [MetaIdWidth-1:0]               data_qid_o,
    output logic                                 data_qvalid_o,
    input  logic                                 data_qready_i,
    input  logic [DataWidth-1:0]                 data_pdata_i,
    input  logic                                 data_perror_i,
    input  logic [MetaIdWidth-1:0]               data_pid_i,
    input  logic                                 data_pvalid_i,
    output logic                                 data_pready_o,
    output logic [CntWidth-1:0]                  outstanding_o
);
    typedef struct packed {
        logic [ReqIdxWidth-1:0] req_idx;
        logic [ReqIdWidth-1:0]  req_id;
    } entry_t;

    logic [ReqIdxWidth-1:0] rr_q, rr_sel, cand, gnt, lock_req_q;
    logic                   lock_q, avail, q_hs, rsp_busy, rsp_hs;
    logic [MetaIdWidth-1:0] lock_id_q, lowest_id, meta_id;
    entry_t                 alloc_entry, rsp_entry;

    // Scan from the highest offset down so the first valid requester at or after rr_q wins.
    always_comb begin
        rr_sel = rr_q;
        cand   = '0;
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
            cand = ReqIdxWidth'((int'(rr_q) + k) % int'(NumReq));
            if (req_qvalid_i[cand]) rr_sel = cand;
        end
    end

    // A stalled request stays pinned to its requester and meta ID until accepted.
    assign gnt           = lock_q ? lock_req_q : rr_sel;
    assign meta_id       = lock_q ? lock_id_q : lowest_id;
    assign data_qvalid_o = req_qvalid_i[gnt] & (avail | lock_q);
    assign q_hs          = data_qvalid_o & data_qready_i;
    assign data_qaddr_o  = req_qaddr_i[gnt];
    assign data_qwrite_o = req_qwrite_i[gnt];
    assign data_qamo_o   = req_qamo_i[gnt];
    assign data_qdata_o  = req_qdata_i[gnt];
    assign data_qstrb_o  = req_qstrb_i[gnt];
    assign data_qid_o    = meta_id;
    assign alloc_entry   = '{req_idx: gnt, req_id: req_qid_i[gnt]};

    always_comb begin
        req_qready_o      = '0;
        req_qready_o[gnt] = q_hs;
    end

    // Responses to a free meta ID are swallowed: accepted but never forwarded.
    always_comb begin
        req_pvalid_o = '0;
        if (rsp_busy) req_pvalid_o[rsp_entry.req_idx] = data_pvalid_i;
    end

    assign data_pready_o = rsp_busy ? req_pready_i[rsp_entry.req_idx] : data_pvalid_i;
    assign rsp_hs        = data_pvalid_i & data_pready_o & rsp_busy;
    assign req_pdata_o   = {NumReq{data_pdata_i}};
    assign req_perror_o  = {NumReq{data_perror_i}};
    assign req_pid_o     = {NumReq{rsp_entry.req_id}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_req_q <= '0;
            lock_id_q  <= '0;
        end else if (q_hs) begin
            rr_q   <= (gnt == ReqIdxWidth'(NumReq - 1)) ? '0 : gnt + 1'b1;
            lock_q <= 1'b0;
        end else if (data_qvalid_o) begin
            lock_q     <= 1'b1;
            lock_req_q <= gnt;
            lock_id_q  <= meta_id;
        end
    end

    tcdm_meta_id_pool #(
        .NumIds     (MaxOutStandingTrans),
        .EntryWidth ($bits(entry_t))
    ) i_pool (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_i       (q_hs),
        .alloc_id_i    (meta_id),
        .alloc_entry_i (alloc_entry),
        .free_i        (rsp_hs),
        .free_id_i     (data_pid_i),
        .rd_id_i       (data_pid_i),
        .rd_entry_o    (rsp_entry),
        .rd_busy_o     (rsp_busy),
        .lowest_id_o   (lowest_id),
        .avail_o       (avail),
        .outstanding_o (outstanding_o)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni) data_pvalid_i |-> rsp_busy)
        else $error("response to free meta id %0d", data_pid_i);
endmodule

// File: tb/tb_tcdm_shim_arbiter.sv
// tb_tcdm_shim_arbiter: vector table plus scripted sequences for the TCDM shim arbiter.
module tb_tcdm_shim_arbiter;
    localparam int NR = 2, AW = 32, DW = 32, SW = 4, MO = 8, IW = 3, MW = 3, OW = 4;

    logic clk = 1'b0, rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0][AW-1:0] req_qaddr;
    logic [NR-1:0]         req_qwrite;
    logic [NR-1:0][3:0]    req_qamo;
    logic [NR-1:0][DW-1:0] req_qdata;
    logic [NR-1:0][SW-1:0] req_qstrb;
    logic [NR-1:0][IW-1:0] req_qid;
    logic [NR-1:0]         req_qvalid, req_qready_o, req_perror_o, req_pvalid_o, req_pready;
    logic [NR-1:0][DW-1:0] req_pdata_o;
    logic [NR-1:0][IW-1:0] req_pid_o;
    logic [AW-1:0] data_qaddr_o;
    logic          data_qwrite_o, data_qvalid_o, data_qready, data_perror, data_pvalid, data_pready_o;
    logic [3:0]    data_qamo_o;
    logic [DW-1:0] data_qdata_o, data_pdata;
    logic [SW-1:0] data_qstrb_o;
    logic [MW-1:0] data_qid_o, data_pid;
    logic [OW-1:0] outstanding_o;

    tcdm_shim_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutStandingTrans(MO), .ReqIdWidth(IW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_qaddr_i(req_qaddr), .req_qwrite_i(req_qwrite), .req_qamo_i(req_qamo),
        .req_qdata_i(req_qdata), .req_qstrb_i(req_qstrb), .req_qid_i(req_qid),
        .req_qvalid_i(req_qvalid), .req_qready_o(req_qready_o),
        .req_pdata_o(req_pdata_o), .req_perror_o(req_perror_o), .req_pid_o(req_pid_o),
        .req_pvalid_o(req_pvalid_o), .req_pready_i(req_pready),
        .data_qaddr_o(data_qaddr_o), .data_qwrite_o(data_qwrite_o), .data_qamo_o(data_qamo_o),
        .data_qdata_o(data_qdata_o), .data_qstrb_o(data_qstrb_o), .data_qid_o(data_qid_o),
        .data_qvalid_o(data_qvalid_o), .data_qready_i(data_qready),
        .data_pdata_i(data_pdata), .data_perror_i(data_perror), .data_pid_i(data_pid),
        .data_pvalid_i(data_pvalid), .data_pready_o(data_pready_o),
        .outstanding_o(outstanding_o)
    );

    typedef struct { int req; int meta; logic [AW-1:0] addr; logic wr; } qexp_t;
    typedef struct { int req; logic [IW-1:0] id; logic [DW-1:0] data; } pexp_t;
    typedef struct { logic [1:0] qv; logic rdy; logic exp_v; int g; logic [1:0] exp_r; int exp_id; } vec_t;

    qexp_t rq[$];
    pexp_t pq[$];
    qexp_t qe;
    pexp_t pe;
    vec_t vecs[12];
    int owner_req[MO];
    logic [IW-1:0] owner_id[MO];
    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int r);
        return (r == 0) ? 32'h0000_0040 : 32'h1000_0080;
    endfunction

    function automatic logic [IW-1:0] id_of(input int r);
        return (r == 0) ? 3'd5 : 3'd2;
    endfunction

    task automatic expect_req(input int r, input int meta);
        rq.push_back('{req: r, meta: meta, addr: addr_of(r), wr: (r == 1)});
        owner_req[meta] = r;
        owner_id[meta]  = id_of(r);
    endtask

    task automatic respond(input int p, input logic [DW-1:0] d);
        data_pvalid = 1'b1;
        data_pid    = MW'(p);
        data_pdata  = d;
        pq.push_back('{req: owner_req[p], id: owner_id[p], data: d});
        @(negedge clk);
        check($sformatf("rsp%0d_pready", p), data_pready_o, 1);
        @(posedge clk); #1;
        data_pvalid = 1'b0;
    endtask

    // Scoreboard: pops the expected grant on every shim handshake and the expected
    // response on every requester-side response handshake.
    always @(negedge clk) if (rst_ni) begin
        if (data_qvalid_o && data_qready) begin
            if (rq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_grant: got meta %0d expected none", data_qid_o);
            end else begin
                qe = rq.pop_front();
                check("grant_ready", req_qready_o, 64'(1) << qe.req);
                check("grant_qid", data_qid_o, qe.meta);
                check("grant_addr", data_qaddr_o, qe.addr);
                check("grant_write", data_qwrite_o, qe.wr);
            end
        end
        for (int r = 0; r < NR; r++) if (req_pvalid_o[r] && req_pready[r]) begin
            if (pq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_rsp: got pvalid on req %0d expected none", r);
            end else begin
                pe = pq.pop_front();
                check("rsp_req", r, pe.req);
                check("rsp_id", req_pid_o[r], pe.id);
                check("rsp_data", req_pdata_o[r], pe.data);
            end
        end
    end

    initial begin
        req_qaddr  = {addr_of(1), addr_of(0)};
        req_qwrite = 2'b10;
        req_qamo   = '0;
        req_qdata  = {32'hCAFE_F00D, 32'h0};
        req_qstrb  = {4'hF, 4'h0};
        req_qid    = {id_of(1), id_of(0)};
        req_qvalid = '0;
        req_pready = 2'b11;
        data_qready = 1'b1;
        data_pdata = '0; data_perror = 1'b0; data_pid = '0; data_pvalid = 1'b0;
        vecs[0]  = '{2'b11, 1'b1, 1'b1, 0, 2'b01, 0};
        vecs[1]  = '{2'b11, 1'b1, 1'b1, 1, 2'b10, 1};
        vecs[2]  = '{2'b11, 1'b1, 1'b1, 0, 2'b01, 2};
        vecs[3]  = '{2'b01, 1'b0, 1'b1, 0, 2'b00, 3};
        vecs[4]  = '{2'b11, 1'b0, 1'b1, 0, 2'b00, 3};
        vecs[5]  = '{2'b11, 1'b0, 1'b1, 0, 2'b00, 3};
        vecs[6]  = '{2'b11, 1'b1, 1'b1, 0, 2'b01, 3};
        vecs[7]  = '{2'b11, 1'b1, 1'b1, 1, 2'b10, 4};
        vecs[8]  = '{2'b11, 1'b1, 1'b1, 0, 2'b01, 5};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 1, 2'b10, 6};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 0, 2'b01, 7};
        vecs[11] = '{2'b11, 1'b1, 1'b0, 0, 2'b00, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_qvalid", data_qvalid_o, 0);
        check("rst_qready", req_qready_o, 0);
        check("rst_pvalid", req_pvalid_o, 0);
        check("rst_pready", data_pready_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Single requester read with response.
        req_qvalid = 2'b01;
        expect_req(0, 0);
        @(negedge clk);
        check("a_qvalid", data_qvalid_o, 1);
        check("a_qid", data_qid_o, 0);
        @(posedge clk); #1;
        req_qvalid = 2'b00;
        check("a_outstanding1", outstanding_o, 1);
        respond(0, 32'h1234_5678);
        check("a_outstanding0", outstanding_o, 0);

        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Alternation, backpressure lock and pool exhaustion.
        for (int i = 0; i < 12; i++) begin
            req_qvalid  = vecs[i].qv;
            data_qready = vecs[i].rdy;
            if (vecs[i].exp_v && vecs[i].rdy) expect_req(vecs[i].g, vecs[i].exp_id);
            @(negedge clk);
            check($sformatf("v%0d_qvalid", i), data_qvalid_o, vecs[i].exp_v);
            check($sformatf("v%0d_qready", i), req_qready_o, vecs[i].exp_r);
            if (vecs[i].exp_v) check($sformatf("v%0d_qid", i), data_qid_o, vecs[i].exp_id);
            @(posedge clk); #1;
        end
        req_qvalid  = 2'b00;
        data_qready = 1'b1;
        check("full_outstanding", outstanding_o, 8);

        // Out-of-order returns.
        respond(7, 32'h7777_0007);
        respond(2, 32'h2222_0002);
        respond(5, 32'h5555_0005);
        check("ooo_outstanding", outstanding_o, 5);

        // Response held off by the requester, then accepted.
        data_pvalid = 1'b1; data_pid = 3'd4; data_pdata = 32'h4444_0004; req_pready = 2'b01;
        @(negedge clk);
        check("bp_pvalid", req_pvalid_o, 2'b10);
        check("bp_pready", data_pready_o, 0);
        check("bp_pid", req_pid_o[1], id_of(1));
        @(posedge clk); #1;
        check("bp_outstanding", outstanding_o, 5);
        req_pready = 2'b11;
        pq.push_back('{req: owner_req[4], id: owner_id[4], data: 32'h4444_0004});
        @(posedge clk); #1;
        data_pvalid = 1'b0;
        check("bp_outstanding_after", outstanding_o, 4);

        // Refill lowest-first: 2, 4, 5, 7.
        req_qvalid = 2'b10;
        foreach (vecs[j]) if (j < 4) begin
            expect_req(1, (j == 0) ? 2 : (j == 1) ? 4 : (j == 2) ? 5 : 7);
            @(negedge clk);
            check($sformatf("refill%0d_qvalid", j), data_qvalid_o, 1);
            @(posedge clk); #1;
        end

        // Pool full while an ID is freed: the waiting request takes it one cycle later.
        data_pvalid = 1'b1; data_pid = 3'd0; data_pdata = 32'h0000_00A0;
        pq.push_back('{req: owner_req[0], id: owner_id[0], data: 32'h0000_00A0});
        @(negedge clk);
        check("fa_qvalid_full", data_qvalid_o, 0);
        check("fa_qready_full", req_qready_o, 0);
        @(posedge clk); #1;
        data_pvalid = 1'b0;
        expect_req(1, 0);
        @(negedge clk);
        check("fa_qvalid_next", data_qvalid_o, 1);
        check("fa_qid_next", data_qid_o, 0);
        @(posedge clk); #1;
        req_qvalid = 2'b00;
        check("fa_outstanding", outstanding_o, 8);

        // Reset mid-cycle with four IDs outstanding.
        respond(3, 32'h3333_0003);
        respond(4, 32'h4444_1004);
        respond(6, 32'h6666_0006);
        respond(1, 32'h1111_0001);
        check("pre_rst_outstanding", outstanding_o, 4);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_outstanding", outstanding_o, 0);
        check("mid_rst_qvalid", data_qvalid_o, 0);
        check("mid_rst_pvalid", req_pvalid_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        req_qvalid = 2'b10;
        expect_req(1, 0);
        @(negedge clk);
        check("post_rst_qid", data_qid_o, 0);
        @(posedge clk); #1;
        req_qvalid = 2'b00;
        respond(0, 32'hDEAD_BEEF);
        check("end_outstanding", outstanding_o, 0);
        check("rq_drained", rq.size(), 0);
        check("pq_drained", pq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tcdm_shim_arbiter.md
Name: tcdm_shim_arbiter

Overview:
- Shares one core-side data port of `tcdm_shim` between NumReq requesters, for example the Snitch LSU and an accelerator or DMA port.
- Arbitrates requests round-robin.
- Remaps each requester ID onto a shim meta ID drawn from a free pool. Sits directly in front of `tcdm_shim` in the tile.
- Responses may return out of order. They are routed back to the issuing requester with its original ID restored.

Parameters:
- NumReq, 2, number of requesters (≥2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; StrbWidth = DataWidth/8.
- MaxOutStandingTrans, 8, size of the meta ID pool; MetaIdWidth = idx_width(MaxOutStandingTrans).
- ReqIdWidth, 3, width of requester-side IDs.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- req_qaddr_i  in  [NumReq][AddrWidth]  request address
- req_qwrite_i  in  [NumReq]  write flag
- req_qamo_i  in  [NumReq][4]  AMO opcode
- req_qdata_i  in  [NumReq][DataWidth]  write data
- req_qstrb_i  in  [NumReq][StrbWidth]  byte strobe
- req_qid_i  in  [NumReq][ReqIdWidth]  requester ID
- req_qvalid_i  in  [NumReq]  request valid
- req_qready_o  out  [NumReq]  request ready
- req_pdata_o  out  [NumReq][DataWidth]  response data
- req_perror_o  out  [NumReq]  response error
- req_pid_o  out  [NumReq][ReqIdWidth]  restored requester ID
- req_pvalid_o  out  [NumReq]  response valid
- req_pready_i  in  [NumReq]  response ready
- data_qaddr_o / data_qwrite_o / data_qamo_o / data_qdata_o / data_qstrb_o  out  as above, single port  to shim
- data_qid_o  out  MetaIdWidth  allocated meta ID
- data_qvalid_o  out  1 ; data_qready_i  in  1
- data_pdata_i  in  DataWidth ; data_perror_i  in  1 ; data_pid_i  in  MetaIdWidth
- data_pvalid_i  in  1 ; data_pready_o  out  1
- outstanding_o  out  idx_width(MaxOutStandingTrans+1)  number of busy meta IDs

Behaviour:
- State:
  - free bitmap `free_q[MaxOutStandingTrans]`, reset to all ones.
  - table entry per meta ID: {req_idx, req_id}, reset to 0.
  - round-robin pointer `rr_q`, reset to 0.
  - lock register {lock_q, lock_req_q, lock_id_q}, reset to 0.
- Reset values of outputs: all valid/ready outputs are 0 and outstanding_o = 0. Data outputs are don't-care, but must not be X when the corresponding valid is 0.
- Allocation: `alloc_id` is the lowest index with `free_q` set. `avail` = |free_q. Both are computed from registered state only, so an ID freed this cycle becomes allocatable next cycle.
- Grant when lock_q = 0: the first valid requester at or after `rr_q`, cyclically, and only if `avail`. When lock_q = 1, the grant is `lock_req_q` and the meta ID is `lock_id_q`.
- Request path, zero latency, combinational:
  - data_qvalid_o = granted request valid & (avail | lock_q).
  - Payload is muxed from the granted requester; data_qid_o = the meta ID.
  - req_qready_o[g] = data_qready_i for the granted requester; 0 for all others.
- Lock: if data_qvalid_o & !data_qready_i, set lock_q with the current grant and ID. Clear it on handshake. Requesters must hold valid and payload stable until ready; the arbiter never withdraws a presented request.
- On request handshake:
  - clear free_q[id];
  - write table[id] = {g, req_qid_i[g]};
  - set rr_q = (g+1) mod NumReq.
- Response path, zero latency:
  - e = table[data_pid_i].
  - req_pvalid_o[e.req_idx] = data_pvalid_i; data and error pass through; req_pid_o = e.req_id.
  - data_pready_o = req_pready_i[e.req_idx].
- On response handshake: set free_q[data_pid_i].
- Response to a free meta ID: illegal. Required behaviour is data_pready_o = 1, response dropped, no req_pvalid_o asserted, and a simulation assertion fires.
- Simultaneous allocate and free of different IDs in one cycle: both are applied. The same ID cannot be both, because allocation only uses free entries.
- Pool full (free_q = 0): data_qvalid_o = 0 and all req_qready_o = 0. Responses still proceed.
- outstanding_o = popcount(~free_q_reg), registered and consistent with free_q.
- Reset mid-operation: pool and table clear immediately. Responses in flight from before reset are illegal and are handled as above.

Decomposition:
- Reuse snitch_pkg::dreq_t/dresp_t for the shim-side payload; no new package typedefs.
- Define the table-entry struct locally, since it depends on parameters.
- One natural sub-module: `tcdm_meta_id_pool`. It owns the free bitmap, lowest-free encoder, table write/read and outstanding count, and is reusable for the SoC meta-ID path.

Test Plan:
- Single requester: req0 issues a read at 0x0000_0040 with id 5, shim ready → data_qid_o = 0. A response with pid 0 reaches req0 with id 5 and outstanding_o returns 1 → 0.
- Both requesters valid every cycle, shim always ready → grants alternate 0,1,0,1 with meta IDs 0,1,2,3.
- Backpressure: hold data_qready_i low for 3 cycles while req1 becomes valid → grant stays req0, data_qid_o stays constant, req1 qready stays 0.
- Out-of-order returns: issue 8 requests, pool full → valid is 0. Return pids 7,2,5 → each is routed to the correct requester and ID; the next allocation uses 2.
- Free and allocate in the same cycle with the pool full → the new request waits one cycle, then takes the freed ID.
- Assert reset with 4 outstanding → outstanding_o = 0, all valids 0, and the next request gets ID 0.
